cmem_bus_ctrl: RTL and testbench

Downstream bus controller for `cmem`. It serves cmem line-refill requests (`b_addr_c`/`b_rd_c` → `b_rdata_c`/`b_dv_c`) by issuing 64-bit beats on the external memory port. It also queues core write-through stores (`b_addr_w`/`b_len_w`/`b_wdata_w`/`b_wr_w`) in a small write buffer and drains them to memory. Each accepted store invalidates the matching cmem line through `inv`/`inv_addr`.

---
 rtl/cmem_bus_pkg.sv | 42 ++++
 rtl/cmem_wbuf.sv | 56 +++++
 rtl/cmem_bus_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cmem_bus_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmem_bus_pkg.sv
// Shared types and constants for the cmem downstream bus controller.
package cmem_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    localparam logic [7:0] BE_BYTE  = 8'h01;
    localparam logic [7:0] BE_HALF  = 8'h03;
    localparam logic [7:0] BE_WORD  = 8'h0F;
    localparam logic [7:0] BE_DWORD = 8'hFF;

    localparam int LINE_W_DEF = 512;
    localparam int LINE_BEATS = LINE_W_DEF / 64;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
    } wb_ent_t;

    localparam int ENT_W = $bits(wb_ent_t);

    function automatic logic [7:0] size_mask(input logic [2:0] len);
        logic [7:0] m;
        unique case (len)
            3'd0:    m = BE_BYTE;
            3'd1:    m = BE_HALF;
            3'd2:    m = BE_WORD;
            default: m = BE_DWORD;
        endcase
        return m;
    endfunction

    function automatic int beats_of(input int line_w);
        return line_w / 64;
    endfunction

endpackage

// File: rtl/cmem_wbuf.sv
// Write buffer: synchronous FIFO of lane-aligned store beats.
module cmem_wbuf
    import cmem_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [ENT_W-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [ENT_W-1:0]             head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q;
    logic [AW-1:0]    rp_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rp_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop)  rp_q <= rp_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= push_data_i;
    end

endmodule

// File: rtl/cmem_bus_ctrl.sv
// cmem bus controller: line refills plus a drained write-through buffer,
// with line invalidation for accepted stores and for stale refills.
module cmem_bus_ctrl
    import cmem_bus_pkg::*;
#(
    parameter int LINE_W   = 512,
    parameter int BLK_W    = 58,
    parameter int WB_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BLK_W-1:0]  b_addr_c,
    input  logic              b_rd_c,
    output logic [LINE_W-1:0] b_rdata_c,
    output logic              b_dv_c,
    input  logic [63:0]       b_addr_w,
    input  logic [2:0]        b_len_w,
    input  logic [63:0]       b_wdata_w,
    input  logic              b_wr_w,
    output logic              stall_w,
    output logic              inv,
    output logic [BLK_W-1:0]  inv_addr,
    output logic [63:0]       m_addr,
    output logic [63:0]       m_wdata,
    output logic [7:0]        m_be,
    output logic              m_we,
    output logic              m_req,
    input  logic              m_ack,
    input  logic [63:0]       m_rdata
);

    localparam int BEATS = LINE_W / 64;
    localparam int BW    = $clog2(BEATS);
    localparam int CW    = $clog2(WB_DEPTH) + 1;

    state_t            state_q, state_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [LINE_W-1:0] line_q;
    wb_ent_t           wr_q;
    wb_ent_t           ent;
    logic [ENT_W-1:0]  head;
    logic              stale_q, stale_d;
    logic              pend_q, pend_d;
    logic [BLK_W-1:0]  pend_addr_q, pend_addr_d;
    logic              inv_q, inv_d;
    logic [BLK_W-1:0]  inv_addr_q, inv_addr_d;
    logic [BLK_W-1:0]  acc_line;
    logic [CW-1:0]     wb_count;
    logic              wb_full;
    logic              wb_empty;
    logic              pop;
    logic              accept;

    assign accept    = b_wr_w && !wb_full;
    assign stall_w   = (wb_count == CW'(WB_DEPTH));
    assign acc_line  = b_addr_w[63:64-BLK_W];
    assign b_rdata_c = line_q;
    assign inv       = inv_q;
    assign inv_addr  = inv_addr_q;

    always_comb begin
        ent.addr = {b_addr_w[63:3], 3'b000};
        ent.be   = size_mask(b_len_w) << b_addr_w[2:0];
        ent.data = b_wdata_w << {b_addr_w[2:0], 3'b000};
    end

    cmem_wbuf #(
        .DEPTH (WB_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .push_i      (accept),
        .push_data_i (ent),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (wb_full),
        .empty_o     (wb_empty),
        .count_o     (wb_count)
    );

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        beat_d  = beat_q;
        pop     = 1'b0;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_be    = '0;
        m_wdata = '0;
        b_dv_c  = 1'b0;
        unique case (state_q)
            // Buffered stores drain first so a refill sees them.
            S_IDLE: begin
                if (!wb_empty) begin
                    pop     = 1'b1;
                    state_d = S_WRITE;
                end else if (b_rd_c) begin
                    blk_d   = b_addr_c;
                    beat_d  = '0;
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                m_req   = 1'b1;
                m_we    = 1'b1;
                m_addr  = wr_q.addr;
                m_be    = wr_q.be;
                m_wdata = wr_q.data;
                if (m_ack) state_d = S_IDLE;
            end
            S_READ: begin
                m_req  = 1'b1;
                m_be   = 8'hFF;
                m_addr = {blk_q, beat_q, 3'b000};
                if (m_ack) begin
                    if (beat_q == BW'(BEATS - 1)) state_d = S_RESP;
                    else                           beat_d = beat_q + BW'(1);
                end
            end
            S_RESP: begin
                b_dv_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stale refill inv wins the slot; a colliding store inv waits one cycle.
    always_comb begin
        stale_d     = stale_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        inv_d       = 1'b0;
        inv_addr_d  = inv_addr_q;
        if (accept && state_q == S_READ && acc_line == blk_q) stale_d = 1'b1;
        if (state_q == S_RESP && stale_q) begin
            stale_d    = 1'b0;
            inv_d      = 1'b1;
            inv_addr_d = blk_q;
            if (accept) begin
                pend_d      = 1'b1;
                pend_addr_d = acc_line;
            end
        end else if (pend_q) begin
            inv_d      = 1'b1;
            inv_addr_d = pend_addr_q;
            pend_d     = accept;
            if (accept) pend_addr_d = acc_line;
        end else if (accept) begin
            inv_d      = 1'b1;
            inv_addr_d = acc_line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            beat_q      <= '0;
            line_q      <= '0;
            wr_q        <= '0;
            stale_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            inv_q       <= 1'b0;
            inv_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            beat_q      <= beat_d;
            stale_q     <= stale_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            inv_q       <= inv_d;
            inv_addr_q  <= inv_addr_d;
            if (pop) wr_q <= head;
            if (state_q == S_READ && m_ack)
                line_q[64*beat_q +: 64] <= m_rdata;
        end
    end

endmodule

// File: tb/tb_cmem_bus_ctrl.sv
// Scoreboard bench for cmem_bus_ctrl: refills, stores, fill, ordering,
// stale-refill invalidation and mid-refill reset.
module tb_cmem_bus_ctrl;

    localparam int LINE_W = 512;
    localparam int BLK_W  = 58;
    localparam int BEATS  = LINE_W / 64;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wd;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [BLK_W-1:0]  b_addr_c;
    logic              b_rd_c;
    logic [LINE_W-1:0] b_rdata_c;
    logic              b_dv_c;
    logic [63:0]       b_addr_w;
    logic [2:0]        b_len_w;
    logic [63:0]       b_wdata_w;
    logic              b_wr_w;
    logic              stall_w;
    logic              inv;
    logic [BLK_W-1:0]  inv_addr;
    logic [63:0]       m_addr;
    logic [63:0]       m_wdata;
    logic [7:0]        m_be;
    logic              m_we;
    logic              m_req;
    logic              m_ack;
    logic [63:0]       m_rdata;
    logic              ack_en;

    int n_vec = 0;
    int n_err = 0;

    beat_t             exp_beats[$];
    logic [LINE_W-1:0] exp_lines[$];
    logic [BLK_W-1:0]  exp_invs[$];

    always #5 clk = ~clk;

    cmem_bus_ctrl #(
        .LINE_W   (LINE_W),
        .BLK_W    (BLK_W),
        .WB_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .b_addr_c  (b_addr_c),
        .b_rd_c    (b_rd_c),
        .b_rdata_c (b_rdata_c),
        .b_dv_c    (b_dv_c),
        .b_addr_w  (b_addr_w),
        .b_len_w   (b_len_w),
        .b_wdata_w (b_wdata_w),
        .b_wr_w    (b_wr_w),
        .stall_w   (stall_w),
        .inv       (inv),
        .inv_addr  (inv_addr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_be      (m_be),
        .m_we      (m_we),
        .m_req     (m_req),
        .m_ack     (m_ack),
        .m_rdata   (m_rdata)
    );

    // Line 1 returns 0x1000+k; other lines are offset in the upper word.
    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        logic [63:0] ln;
        ln = 64'(a[63:6]) - 64'd1;
        return 64'h1000 + 64'(a[5:3]) + (ln << 32);
    endfunction

    function automatic logic [LINE_W-1:0] line_of(input logic [BLK_W-1:0] blk);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < BEATS; k++)
            l[64*k +: 64] = mem_rd({blk, 3'(k), 3'b000});
        return l;
    endfunction

    assign m_ack   = m_req & ack_en;
    assign m_rdata = mem_rd(m_addr);

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m_req && m_ack) begin
                if (exp_beats.size() == 0) begin
                    chk("beat_unexpected", m_addr, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_beats.pop_front();
                    chk("beat_we", m_we, e.we);
                    chk("beat_addr", m_addr, e.addr);
                    chk("beat_be", m_be, e.be);
                    if (e.we) chk("beat_wdata", m_wdata, e.wd);
                end
            end
            if (b_dv_c) begin
                if (exp_lines.size() == 0)
                    chk("line_unexpected", exp_lines.size(), 1);
                else
                    chk("line_data", b_rdata_c, exp_lines.pop_front());
            end
            if (inv) begin
                if (exp_invs.size() == 0)
                    chk("inv_unexpected", inv_addr, '1);
                else
                    chk("inv_addr", inv_addr, exp_invs.pop_front());
            end
        end
    end

    task automatic store(input logic [63:0] a, input logic [2:0] len,
                         input logic [63:0] d, input bit acc);
        beat_t      e;
        logic [7:0] mk;
        b_addr_w  = a;
        b_len_w   = len;
        b_wdata_w = d;
        b_wr_w    = 1'b1;
        @(negedge clk);
        chk("stall_w", stall_w, !acc);
        if (acc) begin
            mk = (len == 3'd0) ? 8'h01 :
                 (len == 3'd1) ? 8'h03 :
                 (len == 3'd2) ? 8'h0F : 8'hFF;
            e.we   = 1'b1;
            e.addr = {a[63:3], 3'b000};
            e.be   = mk << a[2:0];
            e.wd   = d << (8 * a[2:0]);
            exp_beats.push_back(e);
            exp_invs.push_back(a[63:6]);
        end
        @(posedge clk);
        #1 b_wr_w = 1'b0;
    endtask

    task automatic refill(input logic [BLK_W-1:0] blk, input int lat);
        beat_t e;
        int    cyc;
        bit    seen;
        b_addr_c = blk;
        b_rd_c   = 1'b1;
        exp_lines.push_back(line_of(blk));
        for (int k = 0; k < BEATS; k++) begin
            e.we   = 1'b0;
            e.addr = {blk, 3'(k), 3'b000};
            e.be   = 8'hFF;
            e.wd   = '0;
            exp_beats.push_back(e);
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            seen = b_dv_c;
        end
        chk("refill_dv_seen", seen, 1);
        if (lat != 0) chk("refill_latency", cyc, lat);
        @(posedge clk);
        #1 b_rd_c = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_beats.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1 chk("drain_left", exp_beats.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        ack_en    = 1'b1;
        b_addr_c  = '0;
        b_rd_c    = 1'b0;
        b_addr_w  = '0;
        b_len_w   = '0;
        b_wdata_w = '0;
        b_wr_w    = 1'b0;
        #2;
        chk("rst_m_req", m_req, 0);
        chk("rst_b_dv_c", b_dv_c, 0);
        chk("rst_inv", inv, 0);
        chk("rst_stall_w", stall_w, 0);
        chk("rst_rdata", b_rdata_c, 0);
        chk("rst_m_addr", m_addr, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        refill(58'h1, 10);

        store(64'h105, 3'd1, 64'hABCD, 1'b1);
        @(negedge clk);
        chk("st_inv", inv, 1);
        chk("st_inv_addr", inv_addr, 58'h4);
        drain(20);

        store(64'h306, 3'd2, 64'h1122_3344, 1'b1);
        store(64'h308, 3'd5, 64'h0102_0304_0506_0708, 1'b1);
        store(64'h3F0, 3'd0, 64'h5A, 1'b1);
        drain(30);

        ack_en = 1'b0;
        for (int i = 0; i < 5; i++)
            store(64'h400 + 64'(8 * i), 3'd3, 64'hC0DE_0000 + 64'(i), 1'b1);
        store(64'h500, 3'd3, 64'hBAD, 1'b0);
        @(negedge clk);
        chk("fill_stall_hold", stall_w, 1);
        @(posedge clk);
        #1 ack_en = 1'b1;
        drain(40);

        store(64'h600, 3'd3, 64'hDEAD_BEEF, 1'b1);
        refill(58'h3, 0);
        drain(20);

        fork
            refill(58'h1, 10);
            begin
                repeat (3) @(posedge clk);
                #1 store(64'h48, 3'd3, 64'h5555_AAAA, 1'b1);
                exp_invs.push_back(58'h1);
            end
        join
        @(negedge clk);
        chk("stale_inv", inv, 1);
        chk("stale_inv_addr", inv_addr, 58'h1);
        drain(20);

        begin
            beat_t e;
            int    n;
            b_addr_c = 58'h2;
            b_rd_c   = 1'b1;
            for (int k = 0; k < BEATS; k++) begin
                e.we   = 1'b0;
                e.addr = {58'h2, 3'(k), 3'b000};
                e.be   = 8'hFF;
                e.wd   = '0;
                exp_beats.push_back(e);
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(m_req && !m_we && m_addr[5:3] == 3'd2) && n < 30);
            chk("rst_beat3_reached", m_addr, 64'h90);
            #2;
            rst    = 1'b1;
            b_rd_c = 1'b0;
            #1;
            chk("mid_rst_m_req", m_req, 0);
            chk("mid_rst_m_addr", m_addr, 0);
            chk("mid_rst_m_be", m_be, 0);
            chk("mid_rst_b_dv_c", b_dv_c, 0);
            chk("mid_rst_rdata", b_rdata_c, 0);
            chk("mid_rst_inv", inv, 0);
            exp_beats.delete();
            @(posedge clk);
            #1 rst = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        refill(58'h2, 10);

        repeat (4) @(posedge clk);
        #1;
        chk("end_beats", exp_beats.size(), 0);
        chk("end_lines", exp_lines.size(), 0);
        chk("end_invs", exp_invs.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
